// File: rtl/float_to_fix_pipe.sv
// float_to_fix_pipe: 3-stage IEEE-754 single to signed fixed-point converter with rounding and saturation
module float_to_fix_pipe #(
  parameter int FIX_W = 32,
  parameter int POS_W = $clog2(FIX_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      targetnumber,
  input  logic [POS_W-1:0] fixpointpos,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIX_W-1:0] result,
  output logic [2:0]       flags
);
  localparam int IW = FIX_W + 24;
  logic adv;
  logic v1, v2;
  logic s1_sign, s1_zero, s1_nan, s1_inf;
  logic [23:0] s1_mant;
  logic signed [9:0] s1_sh, nsh;
  logic [1:0] s1_mode, s2_mode;
  logic s2_sign, s2_nan, s2_inf, s2_big, s2_g, s2_s;
  logic [FIX_W-1:0] s2_mag, sat;
  logic [6:0] lsh;
  logic [4:0] rsh;
  logic [IW-1:0] lw, iw;
  logic [49:0] ext;
  logic inc, ovf;
  logic [FIX_W:0] rmag;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  always_comb begin
    nsh = -s1_sh;
    lsh = (s1_sh > 10'(FIX_W)) ? 7'(FIX_W) : 7'(s1_sh);
    rsh = (nsh > 10'sd26) ? 5'd26 : 5'(nsh);
    lw = IW'(s1_mant) << lsh;
    ext = {s1_mant, 26'b0} >> rsh;
    iw = s1_sh[9] ? IW'(ext[49:26]) : lw;
    inc = (s2_mode == 2'b01) ? s2_g & (s2_s | s2_mag[0]) :
          (s2_mode == 2'b10) ? s2_sign & (s2_g | s2_s) :
          (s2_mode == 2'b11) ? !s2_sign & (s2_g | s2_s) : 1'b0;
    rmag = {1'b0, s2_mag} + {{FIX_W{1'b0}}, inc};
    ovf = s2_big | rmag[FIX_W] | (rmag[FIX_W-1] & (!s2_sign | (|rmag[FIX_W-2:0])));
    sat = {s2_sign, {(FIX_W-1){!s2_sign}}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_nan <= 1'b0;
      s1_inf <= 1'b0;
      s1_mant <= '0;
      s1_sh <= '0;
      s1_mode <= '0;
      s2_sign <= 1'b0;
      s2_nan <= 1'b0;
      s2_inf <= 1'b0;
      s2_big <= 1'b0;
      s2_g <= 1'b0;
      s2_s <= 1'b0;
      s2_mag <= '0;
      s2_mode <= '0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      s1_sign <= targetnumber[31];
      s1_zero <= targetnumber[30:23] == 8'd0;
      s1_nan <= targetnumber[30:23] == 8'hff && |targetnumber[22:0];
      s1_inf <= targetnumber[30:23] == 8'hff && ~|targetnumber[22:0];
      s1_mant <= {1'b1, targetnumber[22:0]};
      s1_sh <= 10'(targetnumber[30:23]) + 10'(fixpointpos) - 10'd150;
      s1_mode <= rnd_mode;
      s2_sign <= s1_sign;
      s2_nan <= s1_nan;
      s2_inf <= s1_inf;
      s2_big <= !s1_zero && |(iw >> FIX_W);
      s2_g <= !s1_zero && s1_sh[9] && ext[25];
      s2_s <= !s1_zero && s1_sh[9] && |ext[24:0];
      s2_mag <= s1_zero ? '0 : iw[FIX_W-1:0];
      s2_mode <= s1_mode;
      result <= s2_nan ? '0 : (s2_inf || ovf) ? sat : s2_sign ? -rmag[FIX_W-1:0] : rmag[FIX_W-1:0];
      flags <= {s2_nan, !s2_nan && (s2_inf || ovf), !s2_nan && !s2_inf && (s2_g || s2_s)};
    end
endmodule

// File: tb/tb_float_to_fix_pipe.sv
// tb_float_to_fix_pipe: directed checks of float_to_fix_pipe conversion, pipelining, stalls and reset
module tb_float_to_fix_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] targetnumber = '0;
  logic [4:0] fixpointpos = '0;
  logic [1:0] rnd_mode = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0] flags;
  int total = 0;
  int bad = 0;
  logic [31:0] sw [8] = '{32'h3FC00000, 32'hC0300000, 32'h40600000, 32'hBF000000,
                          32'h501502F9, 32'h7FC00000, 32'hCF000000, 32'h3E800000};
  logic [4:0] sp [8] = '{5'd4, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [1:0] sm [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd3};
  logic [31:0] sr [8] = '{32'h18, 32'hFFFFFD40, 32'h4, 32'hFFFFFFFF,
                          32'h7FFFFFFF, 32'h0, 32'h80000000, 32'h1};
  logic [2:0] sf [8] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
  float_to_fix_pipe #(.FIX_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .targetnumber(targetnumber), .fixpointpos(fixpointpos), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run1(input string tag, input logic [31:0] w, input logic [4:0] p, input logic [1:0] m,
                      input logic [31:0] er, input logic [2:0] ef);
    @(negedge clk);
    targetnumber = w;
    fixpointpos = p;
    rnd_mode = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(er));
    chk({tag, "_flags"}, 64'(flags), 64'(ef));
  endtask
  initial begin
    int tx, rx;
    logic held;
    logic [31:0] hres;
    logic [2:0] hflg;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #20;
    rst_n = 1'b1;
    run1("p1_5", 32'h3FC00000, 5'd4, 2'd0, 32'h00000018, 3'b000);
    run1("m2_75_p8", 32'hC0300000, 5'd8, 2'd0, 32'hFFFFFD40, 3'b000);
    run1("m2_75_p1", 32'hC0300000, 5'd1, 2'd0, 32'hFFFFFFFB, 3'b001);
    run1("rne_2_5", 32'h40200000, 5'd0, 2'd1, 32'h2, 3'b001);
    run1("rne_3_5", 32'h40600000, 5'd0, 2'd1, 32'h4, 3'b001);
    run1("rne_2_75", 32'h40300000, 5'd1, 2'd1, 32'h6, 3'b001);
    run1("rne_m2_75", 32'hC0300000, 5'd1, 2'd1, 32'hFFFFFFFA, 3'b001);
    run1("floor_m0_5", 32'hBF000000, 5'd0, 2'd2, 32'hFFFFFFFF, 3'b001);
    run1("ceil_m0_5", 32'hBF000000, 5'd0, 2'd3, 32'h0, 3'b001);
    run1("ceil_0_25", 32'h3E800000, 5'd0, 2'd3, 32'h1, 3'b001);
    run1("ovf_1e10", 32'h501502F9, 5'd0, 2'd0, 32'h7FFFFFFF, 3'b010);
    run1("min_neg", 32'hCF000000, 5'd0, 2'd0, 32'h80000000, 3'b000);
    run1("one_p31", 32'h3F800000, 5'd31, 2'd0, 32'h7FFFFFFF, 3'b010);
    run1("mone_p31", 32'hBF800000, 5'd31, 2'd0, 32'h80000000, 3'b000);
    run1("nan", 32'h7FC00000, 5'd0, 2'd0, 32'h0, 3'b100);
    run1("pinf", 32'h7F800000, 5'd0, 2'd0, 32'h7FFFFFFF, 3'b010);
    run1("ninf", 32'hFF800000, 5'd0, 2'd0, 32'h80000000, 3'b010);
    run1("zero", 32'h00000000, 5'd3, 2'd3, 32'h0, 3'b000);
    run1("neg_denorm", 32'h80000001, 5'd31, 2'd2, 32'h0, 3'b000);
    run1("tiny_ceil", 32'h00800000, 5'd0, 2'd3, 32'h1, 3'b001);
    run1("tiny_trunc", 32'h00800000, 5'd0, 2'd0, 32'h0, 3'b001);
    tx = 0;
    rx = 0;
    held = 1'b0;
    hres = '0;
    hflg = '0;
    for (int c = 0; c < 200 && rx < 8; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid = tx < 8;
      targetnumber = sw[tx % 8];
      fixpointpos = sp[tx % 8];
      rnd_mode = sm[tx % 8];
      #1;
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_result", 64'(result), 64'(hres));
        chk("stall_flags", 64'(flags), 64'(hflg));
      end
      held = out_valid && !out_ready;
      hres = result;
      hflg = flags;
      if (out_valid && out_ready) begin
        chk("stream_result", 64'(result), 64'(sr[rx % 8]));
        chk("stream_flags", 64'(flags), 64'(sf[rx % 8]));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    chk("stream_count", 64'(rx), 64'd8);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) @(negedge clk);
    chk("drained", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      targetnumber = sw[i];
      fixpointpos = sp[i];
      rnd_mode = sm[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags", 64'(flags), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    run1("after_rst", 32'h3FC00000, 5'd4, 2'd0, 32'h00000018, 3'b000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
